// File: rtl/pc_pkg.sv
// Shared constants and helpers for the PC pipeline register family.
package pc_pkg;

  localparam int PC_W_DEFAULT     = 5;
  localparam int RESET_PC_DEFAULT = 0;

  // Bit positions inside the side-band flag vector.
  localparam int FLAG_RMEM = 0;
  localparam int FLAG_WMEM = 1;

  // Bits needed to hold values 0..value-1 (value >= 2 in practice).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One register slot of the PC pipeline: PC, flags and a valid bit.
module pipe_stage
  import pc_pkg::*;
#(
  parameter int              PC_W   = PC_W_DEFAULT,
  parameter int              FLAG_W = 1,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_en,
  input  logic              kill,
  input  logic              d_valid,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [FLAG_W-1:0] d_flag,
  output logic              q_valid,
  output logic [PC_W-1:0]   q_pc,
  output logic [FLAG_W-1:0] q_flag
);

  // kill clears valid/flag but leaves the PC following the normal load/hold path.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_pc    <= RST_PC;
      q_flag  <= '0;
    end else begin
      if (ld_en) begin
        q_pc <= d_pc;
      end
      if (kill) begin
        q_valid <= 1'b0;
        q_flag  <= '0;
      end else if (ld_en) begin
        q_valid <= d_valid;
        q_flag  <= d_flag;
      end
    end
  end

endmodule

// File: rtl/pc_pipe_reg.sv
// DEPTH-stage PC/flag/valid pipeline with global stall, flush and occupancy count.
module pc_pipe_reg
  import pc_pkg::*;
#(
  parameter int          PC_W     = PC_W_DEFAULT,
  parameter int          FLAG_W   = 1,
  parameter int          DEPTH    = 1,
  parameter int unsigned RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        valid_i,
  input  logic [PC_W-1:0]             pc_i,
  input  logic [FLAG_W-1:0]           flag_i,
  output logic                        valid_o,
  output logic [PC_W-1:0]             pc_o,
  output logic [FLAG_W-1:0]           flag_o,
  output logic [clog2(DEPTH+1)-1:0]   occ_o
);

  localparam int              OCC_W  = clog2(DEPTH + 1);
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  // Handshake: a beat is accepted at a posedge only when valid_i=1, stall=0,
  // flush=0 and reset=0; during stall the producer must keep presenting it.
  logic              ld_en;
  logic              kill;
  logic              st_valid [DEPTH];
  logic [PC_W-1:0]   st_pc    [DEPTH];
  logic [FLAG_W-1:0] st_flag  [DEPTH];
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_next;
  logic              last_valid;

  assign ld_en = ~stall;
  assign kill  = flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      pipe_stage #(.PC_W(PC_W), .FLAG_W(FLAG_W), .RST_PC(RST_PC)) u_stage (
        .clock   (clock),
        .reset   (reset),
        .ld_en   (ld_en),
        .kill    (kill),
        .d_valid (valid_i),
        .d_pc    (pc_i),
        .d_flag  (flag_i),
        .q_valid (st_valid[k]),
        .q_pc    (st_pc[k]),
        .q_flag  (st_flag[k])
      );
    end else begin : g_body
      pipe_stage #(.PC_W(PC_W), .FLAG_W(FLAG_W), .RST_PC(RST_PC)) u_stage (
        .clock   (clock),
        .reset   (reset),
        .ld_en   (ld_en),
        .kill    (kill),
        .d_valid (st_valid[k-1]),
        .d_pc    (st_pc[k-1]),
        .d_flag  (st_flag[k-1]),
        .q_valid (st_valid[k]),
        .q_pc    (st_pc[k]),
        .q_flag  (st_flag[k])
      );
    end
  end

  assign last_valid = st_valid[DEPTH-1];

  // Incremental count: one beat may enter and one may leave per shift.
  always_comb begin
    occ_next = occ_q;
    if (flush) begin
      occ_next = '0;
    end else if (!stall) begin
      occ_next = occ_q + OCC_W'(valid_i) - OCC_W'(last_valid);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_next;
    end
  end

  // Outputs are forced to their reset values combinationally while reset is high.
  always_comb begin
    valid_o = 1'b0;
    pc_o    = RST_PC;
    flag_o  = '0;
    occ_o   = '0;
    if (!reset) begin
      valid_o = last_valid;
      pc_o    = st_pc[DEPTH-1];
      flag_o  = st_flag[DEPTH-1] & {FLAG_W{last_valid}};
      occ_o   = occ_q;
    end
  end

endmodule

// File: tb/tb_pc_pipe_reg.sv
// Directed bench for pc_pipe_reg at DEPTH 1, 2 and 8 plus a reference-model soak.
module tb_pc_pipe_reg;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  // DEPTH=2, PC_W=5, FLAG_W=1
  logic       s2, f2, vi2, vo2, fi2, fo2;
  logic [4:0] pi2, po2;
  logic [1:0] oc2;
  // DEPTH=1, PC_W=5, FLAG_W=1
  logic       s1, f1, vi1, vo1, fi1, fo1;
  logic [4:0] pi1, po1;
  logic [0:0] oc1;
  // DEPTH=8, PC_W=8, FLAG_W=3, RESET_PC truncated to 8'h5A
  logic       s8, f8, vi8, vo8;
  logic [7:0] pi8, po8;
  logic [2:0] fi8, fo8;
  logic [3:0] oc8;

  logic [4:0] exp_q[$];

  pc_pipe_reg #(.PC_W(5), .FLAG_W(1), .DEPTH(2), .RESET_PC(0)) u_d2 (
    .clock(clock), .reset(reset), .stall(s2), .flush(f2), .valid_i(vi2),
    .pc_i(pi2), .flag_i(fi2), .valid_o(vo2), .pc_o(po2), .flag_o(fo2), .occ_o(oc2));

  pc_pipe_reg #(.PC_W(5), .FLAG_W(1), .DEPTH(1), .RESET_PC(0)) u_d1 (
    .clock(clock), .reset(reset), .stall(s1), .flush(f1), .valid_i(vi1),
    .pc_i(pi1), .flag_i(fi1), .valid_o(vo1), .pc_o(po1), .flag_o(fo1), .occ_o(oc1));

  pc_pipe_reg #(.PC_W(8), .FLAG_W(3), .DEPTH(8), .RESET_PC(32'h15A)) u_d8 (
    .clock(clock), .reset(reset), .stall(s8), .flush(f8), .valid_i(vi8),
    .pc_i(pi8), .flag_i(fi8), .valid_o(vo8), .pc_o(po8), .flag_o(fo8), .occ_o(oc8));

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Driver for the DEPTH=2 instance
  task automatic drive2(input logic st, input logic fl, input logic v, input logic [4:0] p, input logic fg);
    s2 = st; f2 = fl; vi2 = v; pi2 = p; fi2 = fg;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive2(0, 0, 1, 5'd17, 1);
    tick();
    tick();
    checks++; if (vo2 !== 1'b0) begin errors++; $display("FAIL rst_valid2 got %0d exp 0", vo2); end
    checks++; if (po2 !== 5'd0) begin errors++; $display("FAIL rst_pc2 got %0d exp 0", po2); end
    checks++; if (fo2 !== 1'b0) begin errors++; $display("FAIL rst_flag2 got %0d exp 0", fo2); end
    checks++; if (oc2 !== 2'd0) begin errors++; $display("FAIL rst_occ2 got %0d exp 0", oc2); end
    checks++; if (po8 !== 8'h5A) begin errors++; $display("FAIL rst_pc8_trunc got %0h exp 5a", po8); end
    reset = 1'b0;
    drive2(0, 0, 0, 5'd0, 0);
  endtask

  task automatic test_latency();
    do_reset();
    drive2(0, 0, 1, 5'd3, 1);
    tick();
    checks++; if (oc2 !== 2'd1) begin errors++; $display("FAIL lat_occ1 got %0d exp 1", oc2); end
    checks++; if (vo2 !== 1'b0) begin errors++; $display("FAIL lat_early_valid got %0d exp 0", vo2); end
    drive2(0, 0, 1, 5'd4, 0);
    tick();
    checks++; if (vo2 !== 1'b1) begin errors++; $display("FAIL lat_valid got %0d exp 1", vo2); end
    checks++; if (po2 !== 5'd3) begin errors++; $display("FAIL lat_pc got %0d exp 3", po2); end
    checks++; if (fo2 !== 1'b1) begin errors++; $display("FAIL lat_flag got %0d exp 1", fo2); end
    checks++; if (oc2 !== 2'd2) begin errors++; $display("FAIL lat_occ2 got %0d exp 2", oc2); end
    drive2(0, 0, 0, 5'd4, 1);
    tick();
    checks++; if (po2 !== 5'd4 || vo2 !== 1'b1 || fo2 !== 1'b0) begin errors++; $display("FAIL lat_second got pc %0d v %0d f %0d exp pc 4 v 1 f 0", po2, vo2, fo2); end
    checks++; if (oc2 !== 2'd1) begin errors++; $display("FAIL lat_drain_occ got %0d exp 1", oc2); end
    tick();
    checks++; if (vo2 !== 1'b0 || fo2 !== 1'b0 || oc2 !== 2'd0) begin errors++; $display("FAIL lat_bubble got v %0d f %0d occ %0d exp 0 0 0", vo2, fo2, oc2); end
  endtask

  task automatic test_stall();
    logic [4:0] got;
    do_reset();
    exp_q = '{5'd1, 5'd1, 5'd3};
    s1 = 0; f1 = 0; vi1 = 1; pi1 = 5'd1; fi1 = 1;
    tick();
    got = exp_q.pop_front();
    checks++; if (po1 !== got || vo1 !== 1'b1) begin errors++; $display("FAIL stall_seq0 got pc %0d v %0d exp pc %0d v 1", po1, vo1, got); end
    s1 = 1; pi1 = 5'd2;
    tick();
    got = exp_q.pop_front();
    checks++; if (po1 !== got || vo1 !== 1'b1) begin errors++; $display("FAIL stall_seq1 got pc %0d v %0d exp pc %0d v 1", po1, vo1, got); end
    checks++; if (oc1 !== 1'd1) begin errors++; $display("FAIL stall_occ got %0d exp 1", oc1); end
    s1 = 0; pi1 = 5'd3;
    tick();
    got = exp_q.pop_front();
    checks++; if (po1 !== got || vo1 !== 1'b1) begin errors++; $display("FAIL stall_seq2 got pc %0d v %0d exp pc %0d v 1", po1, vo1, got); end
    vi1 = 0;
    tick();
    checks++; if (vo1 !== 1'b0 || fo1 !== 1'b0 || oc1 !== 1'd0) begin errors++; $display("FAIL stall_drain got v %0d f %0d occ %0d exp 0 0 0", vo1, fo1, oc1); end
  endtask

  task automatic test_flush();
    do_reset();
    drive2(0, 0, 1, 5'd10, 1);
    tick();
    drive2(0, 0, 1, 5'd11, 1);
    tick();
    checks++; if (oc2 !== 2'd2 || po2 !== 5'd10) begin errors++; $display("FAIL flush_full got occ %0d pc %0d exp occ 2 pc 10", oc2, po2); end
    drive2(0, 1, 1, 5'd12, 1);
    tick();
    checks++; if (vo2 !== 1'b0 || fo2 !== 1'b0 || oc2 !== 2'd0) begin errors++; $display("FAIL flush_clear got v %0d f %0d occ %0d exp 0 0 0", vo2, fo2, oc2); end
    checks++; if (po2 !== 5'd11) begin errors++; $display("FAIL flush_pc_shift got %0d exp 11", po2); end
    drive2(0, 0, 1, 5'd13, 1);
    tick();
    checks++; if (vo2 !== 1'b0 || oc2 !== 2'd1) begin errors++; $display("FAIL flush_discard got v %0d occ %0d exp v 0 occ 1", vo2, oc2); end
    drive2(0, 0, 0, 5'd0, 0);
    tick();
    checks++; if (vo2 !== 1'b1 || po2 !== 5'd13 || fo2 !== 1'b1) begin errors++; $display("FAIL flush_refill got v %0d pc %0d f %0d exp 1 13 1", vo2, po2, fo2); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive2(0, 0, 1, 5'd6, 1);
    tick();
    drive2(0, 0, 1, 5'd7, 1);
    tick();
    drive2(1, 1, 1, 5'd9, 1);
    tick();
    checks++; if (po2 !== 5'd6 || vo2 !== 1'b0 || fo2 !== 1'b0 || oc2 !== 2'd0) begin errors++; $display("FAIL sf_hold got pc %0d v %0d f %0d occ %0d exp 6 0 0 0", po2, vo2, fo2, oc2); end
    drive2(0, 0, 0, 5'd1, 0);
    tick();
    checks++; if (po2 !== 5'd7 || vo2 !== 1'b0) begin errors++; $display("FAIL sf_stage0_pc got pc %0d v %0d exp 7 0", po2, vo2); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive2(0, 0, 1, 5'd8, 1);
    tick();
    drive2(0, 0, 1, 5'd9, 1);
    tick();
    drive2(0, 0, 1, 5'd10, 1);
    tick();
    checks++; if (po2 !== 5'd9 || oc2 !== 2'd2) begin errors++; $display("FAIL mid_pre got pc %0d occ %0d exp 9 2", po2, oc2); end
    reset = 1'b1;
    #1;
    checks++; if (po2 !== 5'd0 || vo2 !== 1'b0 || fo2 !== 1'b0 || oc2 !== 2'd0) begin errors++; $display("FAIL mid_mask got pc %0d v %0d f %0d occ %0d exp 0 0 0 0", po2, vo2, fo2, oc2); end
    tick();
    reset = 1'b0;
    drive2(0, 0, 0, 5'd0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (vo2 !== 1'b0 || oc2 !== 2'd0) begin errors++; $display("FAIL mid_stale%0d got v %0d occ %0d exp 0 0", i, vo2, oc2); end
    end
  endtask

  // Reference model of the DEPTH=8 pipeline built from the stated shift/stall/flush rules.
  task automatic test_soak();
    logic       m_v  [8];
    logic [7:0] m_pc [8];
    logic [2:0] m_f  [8];
    logic [3:0] pop;
    logic [2:0] exp_f;
    do_reset();
    for (int k = 0; k < 8; k++) begin m_v[k] = 0; m_pc[k] = 8'h5A; m_f[k] = 0; end
    for (int c = 0; c < 3000; c++) begin
      s8 = ($urandom_range(0, 3) == 0);
      f8 = ($urandom_range(0, 19) == 0);
      vi8 = $urandom_range(0, 1);
      pi8 = 8'($urandom_range(0, 255));
      fi8 = 3'($urandom_range(0, 7));
      if (!s8) begin
        for (int k = 7; k > 0; k--) begin m_v[k] = m_v[k-1]; m_pc[k] = m_pc[k-1]; m_f[k] = m_f[k-1]; end
        m_v[0] = vi8; m_pc[0] = pi8; m_f[0] = fi8;
      end
      if (f8) begin
        for (int k = 0; k < 8; k++) begin m_v[k] = 0; m_f[k] = 0; end
      end
      tick();
      pop = 0;
      for (int k = 0; k < 8; k++) pop = pop + 4'(m_v[k]);
      exp_f = m_v[7] ? m_f[7] : 3'd0;
      checks++; if (vo8 !== m_v[7]) begin errors++; $display("FAIL soak_valid c%0d got %0d exp %0d", c, vo8, m_v[7]); end
      checks++; if (po8 !== m_pc[7]) begin errors++; $display("FAIL soak_pc c%0d got %0h exp %0h", c, po8, m_pc[7]); end
      checks++; if (fo8 !== exp_f) begin errors++; $display("FAIL soak_flag c%0d got %0h exp %0h", c, fo8, exp_f); end
      checks++; if (oc8 !== pop) begin errors++; $display("FAIL soak_occ c%0d got %0d exp %0d", c, oc8, pop); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    drive2(0, 0, 0, 5'd0, 0);
    s1 = 0; f1 = 0; vi1 = 0; pi1 = 0; fi1 = 0;
    s8 = 0; f8 = 0; vi8 = 0; pi8 = 0; fi8 = 0;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_stall_flush();
    test_reset_midstream();
    test_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
